// File: rtl/pico_tx_master.sv
// PICO write serializer: address byte + N data bytes, MSB-first, then idle gap.
// Optional start screening with `PICO_TX_ADDR_CHECK_EN.
module pico_tx_master #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 10
) (
  input  logic       iclk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] len,
  input  logic [7:0] wdata,
  input  logic       wdata_valid,
  output logic       wdata_ready,
  output logic       sclk_out,
  output logic       sdo,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_PRE  = CW'(GAP_CYCLES - 2);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic [7:0]    remaining;
  logic [7:0]    buf_q;
  logic          buf_full;
  logic          aborted;
  logic          done_q;
  logic          err_q;
  logic          run;
  logic          hs;
  logic          phase_end;
  logic          reject;

`ifdef PICO_TX_ADDR_CHECK_EN
  // addr 0 means "no pointer"; wrapping past 0xFF would turn data into an address
  assign reject = (addr == 8'd0) ||
                  (({1'b0, addr} + {1'b0, len}) > 9'd256);
`else
  assign reject = 1'b0;
`endif

  assign run         = (state == S_LOW) || (state == S_HIGH);
  assign wdata_ready = run && !buf_full && (remaining != 8'd0);
  assign hs          = wdata_valid && wdata_ready;
  assign phase_end   = (cnt == DIV_LAST);

  assign sclk_out = (state == S_HIGH);
  assign sdo      = run & shreg[7];
  assign busy     = (state != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;

  always_ff @(posedge iclk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitcnt    <= 3'd0;
      shreg     <= 8'd0;
      remaining <= 8'd0;
      buf_q     <= 8'd0;
      buf_full  <= 1'b0;
      aborted   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (hs) begin
        buf_q    <= wdata;
        buf_full <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              shreg     <= addr;
              remaining <= len;
              bitcnt    <= 3'd7;
              cnt       <= '0;
              aborted   <= 1'b0;
              buf_full  <= 1'b0;
              state     <= S_LOW;
            end
          end
        end
        S_LOW: begin
          if (phase_end) begin
            cnt   <= '0;
            state <= S_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!phase_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (bitcnt != 3'd0) begin
              shreg  <= {shreg[6:0], 1'b0};
              bitcnt <= bitcnt - 1'b1;
              state  <= S_LOW;
            end else if (remaining == 8'd0) begin
              state <= S_GAP;
            end else if (buf_full) begin
              shreg     <= buf_q;
              buf_full  <= 1'b0;
              remaining <= remaining - 1'b1;
              bitcnt    <= 3'd7;
              state     <= S_LOW;
            end else begin
              // underrun: bytes already sent stay written, close early
              err_q    <= 1'b1;
              aborted  <= 1'b1;
              buf_full <= 1'b0;
              state    <= S_GAP;
            end
          end
        end
        S_GAP: begin
          buf_full <= 1'b0;
          if ((cnt == GAP_PRE) && !aborted)
            done_q <= 1'b1;
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_tx_master.sv
// Bench for pico_tx_master: cycle-level timeline model, directed and random transactions.
// Honors `PICO_TX_ADDR_CHECK_EN when defined for the build.
module tb_pico_tx_master;

  localparam int D   = 2;
  localparam int GAP = 10;
  localparam int P   = 2 * D;
  localparam int T   = 8 * P;

  logic       iclk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] len = 8'd0;
  logic [7:0] wdata = 8'd0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic       sclk_out;
  logic       sdo;
  logic       busy;
  logic       done;
  logic       err;

  pico_tx_master #(.CLK_DIV(D), .GAP_CYCLES(GAP)) dut (
    .iclk(iclk), .rst(rst), .start(start), .addr(addr), .len(len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .sclk_out(sclk_out), .sdo(sdo), .busy(busy), .done(done), .err(err)
  );

  always #5 iclk = ~iclk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // model: 0 idle, 1 shifting, 2 gap
  int         m_state = 0;
  int         kk = 0;
  int         g = 0;
  logic [7:0] m_cur = 8'd0;
  logic [7:0] m_buf = 8'd0;
  bit         m_buf_full = 0;
  int         m_rem = 0;
  bit         m_abort = 0;
  bit         m_err_pend = 0;
  int         n_hs = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cyc = -1;
  int         err_cyc = -1;
  int         rise_cyc = -1;
  logic [7:0] frame[$];
  logic [7:0] rx_acc = 8'd0;
  int         rx_n = 0;
  bit         prev_sclk = 0;

  logic [7:0] feed_q[$];
  int         feed_mode = 0;
  int         feed_cnt = 0;
  bit         hs_pending = 0;

  always @(negedge iclk) begin
    logic e_sclk, e_sdo, e_busy, e_rdy, e_done, e_err;
    bit rej, hsx;
    int ph, bp;
    e_sclk = 0; e_sdo = 0; e_busy = 0;
    e_rdy = 0; e_done = 0; e_err = 0;
    rej = 0; hsx = 0;
    if (m_state == 0) begin
      e_err = m_err_pend;
    end else if (m_state == 1) begin
      ph     = kk % P;
      bp     = (kk % T) / P;
      e_sclk = (ph >= D);
      e_sdo  = m_cur[7 - bp];
      e_busy = 1;
      e_rdy  = !m_buf_full && (m_rem > 0);
    end else begin
      e_busy = 1;
      e_done = (g == GAP - 1) && !m_abort;
      e_err  = (g == 0) && m_abort;
    end
    if (chk_en)
      chk("outputs", {sclk_out, sdo, busy, wdata_ready, done, err},
          {e_sclk, e_sdo, e_busy, e_rdy, e_done, e_err});
    if (wdata_valid && wdata_ready) hs_pending = 1;
    if (done) done_cyc = cyc;
    if (err) err_cyc = cyc;
    if (sclk_out && !prev_sclk) begin
      if (rise_cyc < 0) rise_cyc = cyc;
      rx_acc = {rx_acc[6:0], sdo};
      rx_n++;
      if (rx_n == 8) begin
        frame.push_back(rx_acc);
        rx_n = 0;
      end
    end
    prev_sclk = sclk_out;
    m_err_pend = 0;
    if (rst) begin
      m_state = 0;
      m_buf_full = 0;
    end else if (m_state == 0) begin
      if (start) begin
`ifdef PICO_TX_ADDR_CHECK_EN
        rej = (addr == 8'd0) || (int'(addr) + int'(len) > 256);
`endif
        if (rej) begin
          m_err_pend = 1;
        end else begin
          m_state = 1; kk = 0;
          m_cur = addr; m_rem = int'(len);
          m_buf_full = 0; m_abort = 0; n_hs = 0;
          start_cyc = cyc; done_cyc = -1; err_cyc = -1;
          rise_cyc = -1; frame.delete(); rx_n = 0;
        end
      end
    end else if (m_state == 1) begin
      hsx = e_rdy && wdata_valid;
      if (hsx) n_hs++;
      if (kk % T == T - 1) begin
        if (m_rem == 0) begin
          m_state = 2; g = 0;
        end else if (m_buf_full) begin
          m_cur = m_buf; m_rem--; m_buf_full = 0; kk++;
        end else begin
          m_abort = 1; m_state = 2; g = 0;
        end
      end else begin
        kk++;
      end
      if (hsx) begin
        m_buf = wdata; m_buf_full = 1;
      end
      if (m_state == 2) m_buf_full = 0;
    end else begin
      if (g == GAP - 1) m_state = 0;
      else g++;
    end
    cyc++;
  end

  // data source: presents queue head, pops after each accepted handshake
  initial begin
    forever begin
      @(posedge iclk); #1;
      if (hs_pending) begin
        if (feed_q.size() > 0) void'(feed_q.pop_front());
        feed_cnt++;
        hs_pending = 0;
      end
      wdata = (feed_q.size() > 0) ? feed_q[0] : 8'($urandom);
      case (feed_mode)
        0: wdata_valid = (feed_q.size() > 0);
        1: wdata_valid = (feed_q.size() > 0) && ($urandom_range(0, 3) != 0);
        default: wdata_valid = (feed_q.size() > 0) && (feed_cnt == 0);
      endcase
    end
  end

  task automatic cyc1();
    @(posedge iclk); #1;
  endtask

  task automatic go(input logic [7:0] a, input logic [7:0] l);
    start = 1; addr = a; len = l;
    cyc1();
    start = 0; addr = 8'($urandom); len = 8'($urandom);
  endtask

  task automatic setup(input int mode);
    feed_q.delete();
    feed_mode = mode;
    feed_cnt = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((busy || m_state != 0) && n < lim) begin
      start = busy && ($urandom_range(0, 15) == 0) && (feed_mode == 1);
      cyc1();
      start = 0;
      n++;
    end
    if (n >= lim) chk("timeout", 1, 0);
    cyc1();
  endtask

  logic [7:0] mem[256];

  initial begin
    cyc1();
    chk_en = 1;
    cyc1();
    rst = 0;
    @(negedge iclk);
    chk("reset", {sclk_out, sdo, busy, wdata_ready, done, err}, 0);
    cyc1();

    // address-only frame
    setup(0);
    go(8'h12, 8'd0);
    wait_idle(500);
    chk("t1_nbytes", frame.size(), 1);
    if (frame.size() > 0) chk("t1_addr", frame[0], 8'h12);
    chk("t1_done_at", done_cyc - start_cyc, 42);
    chk("t1_first_rise", rise_cyc - start_cyc, 1 + D);

    // three data bytes, always valid
    setup(0);
    feed_q = '{8'hA5, 8'h3C, 8'hFF};
    go(8'h05, 8'd3);
    wait_idle(500);
    chk("t2_hs", n_hs, 3);
    chk("t2_nbytes", frame.size(), 4);
    if (frame.size() == 4) begin
      for (int i = 1; i < 4; i++) mem[8'(frame[0] + 8'(i - 1))] = frame[i];
      chk("t2_mem05", mem[5], 8'hA5);
      chk("t2_mem06", mem[6], 8'h3C);
      chk("t2_mem07", mem[7], 8'hFF);
    end
    chk("t2_done_at", done_cyc - start_cyc, 138);

    // underrun on the second data byte
    setup(2);
    feed_q = '{8'h11, 8'h22};
    go(8'h40, 8'd2);
    wait_idle(500);
    chk("t3_err_at", err_cyc - start_cyc, 65);
    chk("t3_no_done", done_cyc, -1);
    chk("t3_nbytes", frame.size(), 2);

    // reset in the 5th bit of the first data byte
    setup(0);
    feed_q = '{8'hC3, 8'h5A};
    go(8'h20, 8'd2);
    repeat (48) cyc1();
    rst = 1;
    cyc1();
    rst = 0;
    setup(0);
    @(negedge iclk);
    chk("t4_after_rst", {sclk_out, sdo, busy}, 0);
    go(8'h30, 8'd0);
    @(negedge iclk);
    chk("t4_restart_busy", busy, 1);
    wait_idle(500);
    if (frame.size() > 0) chk("t4_addr", frame[0], 8'h30);

    // start pulsed while busy is ignored
    setup(0);
    feed_q = '{8'h77};
    go(8'h50, 8'd1);
    repeat (20) cyc1();
    start = 1; addr = 8'h00; len = 8'd5;
    cyc1();
    start = 0;
    wait_idle(500);
    chk("t5_done_at", done_cyc - start_cyc, 74);

`ifdef PICO_TX_ADDR_CHECK_EN
    setup(0);
    go(8'h00, 8'd1);
    @(negedge iclk);
    chk("t6_zero_err", {busy, err}, 2'b01);
    cyc1();
    go(8'hFE, 8'd3);
    @(negedge iclk);
    chk("t6_wrap_err", {busy, err}, 2'b01);
    cyc1();
    feed_q = '{8'h01, 8'h02};
    go(8'hFE, 8'd2);
    @(negedge iclk);
    chk("t6_ok_busy", {busy, err}, 2'b10);
    wait_idle(500);
`endif

    // randomized traffic with sparse valid and stray start pulses
    for (int t = 0; t < 25; t++) begin
      int l;
      l = $urandom_range(0, 3);
      setup(1);
      for (int i = 0; i < l; i++) feed_q.push_back(8'($urandom));
      go(8'($urandom_range(1, 255)), 8'(l));
      wait_idle(2000);
      repeat ($urandom_range(0, 3)) cyc1();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
